// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the two-master arbiter: state encoding,
// request/response bundles and the arbitration decision.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = WB_DATA_W / 8;

  // Arbiter states; ABORT parks the bus after a watchdog abort until the owner lets go
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat;
    logic [WB_SEL_W-1:0]  sel;
  } wb_req_t;

  typedef struct packed {
    logic [WB_DATA_W-1:0] dat;
    logic                 ack;
    logic                 err;
  } wb_rsp_t;

  // Picks the next owner from the two cyc lines; on a tie round-robin favours
  // the master that did not own the bus last, fixed priority favours master 0
  function automatic arb_state_e arbitrate(input logic cyc0, input logic cyc1,
                                           input logic last_grant, input logic fixed_pri);
    arb_state_e nxt;
    nxt = IDLE;
    if (cyc0 && cyc1) begin
      nxt = (fixed_pri || last_grant) ? GNT0 : GNT1;
    end else if (cyc0) begin
      nxt = GNT0;
    end else if (cyc1) begin
      nxt = GNT1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog: counts stalled strobe cycles and fires a one-cycle pulse
// when the slave has been silent for TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0
// disables it entirely.
module wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic fire_o
);

  // A disabled watchdog can ask for a zero-width counter; keep at least one bit
  localparam int            CW       = (TO_WIDTH < 1) ? 1 : TO_WIDTH;
  localparam bit            ENABLED  = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST_CNT = ENABLED ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  assign fire_o = ENABLED && active_i && enable_i && (cnt_q == LAST_CNT);

  // Next count: cleared on termination, on firing or when no cycle is owned
  always_comb begin
    cnt_d = cnt_q;
    if (!ENABLED || !active_i || clear_i || fire_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter. Master 0 is the load/store unit,
// master 1 is instruction fetch. Ownership lasts a whole cyc period; a
// watchdog aborts cycles the slave never terminates.
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam logic FIXED_PRI = (FIXED_PRIORITY != 0);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       own_cyc;
  logic       in_gnt;
  logic       wd_fire;

  // In ABORT the aborted owner is still remembered by last_grant
  assign own_cyc = ((state_q == GNT1) || ((state_q == ABORT) && last_grant_q)) ? m1_cyc_i : m0_cyc_i;
  assign in_gnt  = (state_q == GNT0) || (state_q == GNT1);

  wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .active_i (in_gnt),
    .enable_i (s_stb_o & ~s_ack_i & ~s_err_i),
    .clear_i  (s_ack_i | s_err_i | ~own_cyc),
    .fire_o   (wd_fire)
  );

  // Next owner: re-arbitrate only once the current owner has dropped cyc
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = arbitrate(m0_cyc_i, m1_cyc_i, last_grant_q, FIXED_PRI);
      GNT0, GNT1: begin
        if (!own_cyc) begin
          state_d = arbitrate(m0_cyc_i, m1_cyc_i, last_grant_q, FIXED_PRI);
        end else if (wd_fire) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = arbitrate(m0_cyc_i, m1_cyc_i, last_grant_q, FIXED_PRI);
        end
      end
      default: state_d = IDLE;
    endcase

    last_grant_d = last_grant_q;
    if (state_d == GNT0) begin
      last_grant_d = 1'b0;
    end else if (state_d == GNT1) begin
      last_grant_d = 1'b1;
    end
  end

  // State and fairness registers; master 0 wins the first tie after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Bus mux: the owner drives the slave, everything is zero when nobody owns it
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    grant_o   = 2'b00;
    unique case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i & m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | wd_fire;
        grant_o  = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i & m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | wd_fire;
        grant_o  = 2'b10;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

  assign timeout_o = wd_fire;
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: one round-robin instance with an 8-cycle watchdog
// and one fixed-priority instance with the watchdog disabled, driven by the
// same masters and slave, each checked every cycle against an ownership model.
module tb_wb_arbiter_2m;

  typedef logic [141:0] vec_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        m0Cyc, m0Stb, m0We, m1Cyc, m1Stb, m1We;
  logic [31:0] m0Adr, m0Dat, m1Adr, m1Dat, sDatIn;
  logic [3:0]  m0Sel, m1Sel;
  logic        sAck, sErr;

  logic [31:0] m0DatOut[2], m1DatOut[2], sAdrOut[2], sDatOut[2];
  logic        m0AckOut[2], m0ErrOut[2], m1AckOut[2], m1ErrOut[2];
  logic        sCycOut[2], sStbOut[2], sWeOut[2], timeoutOut[2];
  logic [3:0]  sSelOut[2];
  logic [1:0]  grantOut[2];

  int assertCount = 0;
  int failCount   = 0;

  // model state per instance: owner -1 = nobody
  int owner[2];
  int waitCnt[2];
  bit aborted[2];
  bit lastG[2];

  always #5 clk = ~clk;

  wb_arbiter_2m #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(8)) dutRr (
    .clk_i(clk), .rst_ni(rstN),
    .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb), .m0_we_i(m0We), .m0_adr_i(m0Adr), .m0_dat_i(m0Dat), .m0_sel_i(m0Sel),
    .m0_dat_o(m0DatOut[0]), .m0_ack_o(m0AckOut[0]), .m0_err_o(m0ErrOut[0]),
    .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb), .m1_we_i(m1We), .m1_adr_i(m1Adr), .m1_dat_i(m1Dat), .m1_sel_i(m1Sel),
    .m1_dat_o(m1DatOut[0]), .m1_ack_o(m1AckOut[0]), .m1_err_o(m1ErrOut[0]),
    .s_cyc_o(sCycOut[0]), .s_stb_o(sStbOut[0]), .s_we_o(sWeOut[0]), .s_adr_o(sAdrOut[0]),
    .s_dat_o(sDatOut[0]), .s_sel_o(sSelOut[0]), .s_dat_i(sDatIn), .s_ack_i(sAck), .s_err_i(sErr),
    .grant_o(grantOut[0]), .timeout_o(timeoutOut[0])
  );

  wb_arbiter_2m #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(0)) dutFp (
    .clk_i(clk), .rst_ni(rstN),
    .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb), .m0_we_i(m0We), .m0_adr_i(m0Adr), .m0_dat_i(m0Dat), .m0_sel_i(m0Sel),
    .m0_dat_o(m0DatOut[1]), .m0_ack_o(m0AckOut[1]), .m0_err_o(m0ErrOut[1]),
    .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb), .m1_we_i(m1We), .m1_adr_i(m1Adr), .m1_dat_i(m1Dat), .m1_sel_i(m1Sel),
    .m1_dat_o(m1DatOut[1]), .m1_ack_o(m1AckOut[1]), .m1_err_o(m1ErrOut[1]),
    .s_cyc_o(sCycOut[1]), .s_stb_o(sStbOut[1]), .s_we_o(sWeOut[1]), .s_adr_o(sAdrOut[1]),
    .s_dat_o(sDatOut[1]), .s_sel_o(sSelOut[1]), .s_dat_i(sDatIn), .s_ack_i(sAck), .s_err_i(sErr),
    .grant_o(grantOut[1]), .timeout_o(timeoutOut[1])
  );

  function automatic int timeoutOf(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  function automatic bit fixedOf(input int k);
    return (k == 1);
  endfunction

  task automatic checkValue(input string tag, input vec_t obs, input vec_t exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset(input int k);
    owner[k]   = -1;
    waitCnt[k] = 0;
    aborted[k] = 1'b0;
    lastG[k]   = 1'b1;
  endtask

  function automatic logic ownerCyc(input int k);
    return (owner[k] == 1) ? m1Cyc : m0Cyc;
  endfunction

  function automatic logic ownerStb(input int k);
    return (owner[k] == 1) ? (m1Cyc & m1Stb) : (m0Cyc & m0Stb);
  endfunction

  function automatic logic modelFire(input int k);
    if (!rstN || owner[k] < 0 || aborted[k] || timeoutOf(k) == 0) return 1'b0;
    return ownerStb(k) && !sAck && !sErr && (waitCnt[k] == timeoutOf(k) - 1);
  endfunction

  function automatic vec_t expected(input int k);
    logic [1:0]  g;
    logic        tmo, cy, st, we, a0, e0, a1, e1;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        f;
    g = 2'b00; tmo = 0; cy = 0; st = 0; we = 0; a0 = 0; e0 = 0; a1 = 0; e1 = 0;
    sel = '0; adr = '0; dat = '0;
    f = modelFire(k);
    if (rstN && owner[k] >= 0 && !aborted[k]) begin
      tmo = f;
      if (owner[k] == 0) begin
        g = 2'b01; cy = m0Cyc; st = m0Cyc & m0Stb; we = m0We; adr = m0Adr; dat = m0Dat; sel = m0Sel;
        a0 = sAck; e0 = sErr | f;
      end else begin
        g = 2'b10; cy = m1Cyc; st = m1Cyc & m1Stb; we = m1We; adr = m1Adr; dat = m1Dat; sel = m1Sel;
        a1 = sAck; e1 = sErr | f;
      end
    end
    return {g, tmo, cy, st, we, a0, e0, a1, e1, sel, adr, dat, sDatIn, sDatIn};
  endfunction

  function automatic vec_t observed(input int k);
    return {grantOut[k], timeoutOut[k], sCycOut[k], sStbOut[k], sWeOut[k],
            m0AckOut[k], m0ErrOut[k], m1AckOut[k], m1ErrOut[k],
            sSelOut[k], sAdrOut[k], sDatOut[k], m0DatOut[k], m1DatOut[k]};
  endfunction

  // ownership rules applied at a clock edge with the inputs of the closing cycle
  task automatic advanceModel();
    for (int k = 0; k < 2; k++) begin
      if (!rstN) begin
        modelReset(k);
      end else if (owner[k] < 0 || !ownerCyc(k)) begin
        if (m0Cyc && m1Cyc) owner[k] = (fixedOf(k) || lastG[k]) ? 0 : 1;
        else if (m0Cyc)     owner[k] = 0;
        else if (m1Cyc)     owner[k] = 1;
        else                owner[k] = -1;
        aborted[k] = 1'b0;
        waitCnt[k] = 0;
        if (owner[k] >= 0) lastG[k] = (owner[k] == 1);
      end else if (aborted[k]) begin
        waitCnt[k] = 0;
      end else if (modelFire(k)) begin
        aborted[k] = 1'b1;
        waitCnt[k] = 0;
      end else if (sAck || sErr) begin
        waitCnt[k] = 0;
      end else if (ownerStb(k)) begin
        waitCnt[k]++;
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("rr_bus", observed(0), expected(0));
    checkValue("fp_bus", observed(1), expected(1));
  endtask

  task automatic applyStimulus(input logic c0, input logic s0, input logic c1, input logic s1);
    m0Cyc = c0; m0Stb = s0; m1Cyc = c1; m1Stb = s1;
    m0We  = 1'($urandom); m1We = 1'($urandom);
    m0Adr = $urandom; m0Dat = $urandom; m0Sel = 4'($urandom);
    m1Adr = $urandom; m1Dat = $urandom; m1Sel = 4'($urandom);
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic tick();
    advanceModel();
    @(posedge clk);
    #1;
  endtask

  // hard stop in case the run wanders off
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int rem[2];
    bit dropNext[2];
    int grantSeq[$];
    int idleSeen;
    logic c0, c1;
    logic prevM0Cyc;
    logic [1:0] prevGrantFp;
    int ackDiv;

    rstN = 1'b0; sAck = 0; sErr = 0; sDatIn = '0;
    applyStimulus(0, 0, 0, 0);
    modelReset(0); modelReset(1);

    #1;
    checkValue("reset_grant", vec_t'(grantOut[0]), vec_t'(2'b00));
    checkValue("reset_scyc_sstb", vec_t'({sCycOut[0], sStbOut[0], sCycOut[1], sStbOut[1]}), vec_t'(4'b0000));
    sampleCycle();
    tick();
    rstN = 1'b1;

    // single master read with ack two cycles after the grant
    applyStimulus(1, 1, 0, 0);
    m0We = 1'b0; m0Adr = 32'h8000_0004;
    sampleCycle();
    checkValue("req_not_yet_granted", vec_t'(sStbOut[0]), vec_t'(1'b0));
    tick();
    sampleCycle();
    checkValue("single_stb", vec_t'({sStbOut[0], grantOut[0]}), vec_t'({1'b1, 2'b01}));
    checkValue("single_adr", vec_t'(sAdrOut[0]), vec_t'(32'h8000_0004));
    tick();
    sAck = 1'b1; sDatIn = 32'hDEAD_BEEF;
    sampleCycle();
    checkValue("single_ack", vec_t'({m0AckOut[0], m1AckOut[0]}), vec_t'(2'b10));
    checkValue("single_rdata", vec_t'(m0DatOut[0]), vec_t'(32'hDEAD_BEEF));
    tick();
    sAck = 1'b0;
    applyStimulus(0, 0, 0, 0);
    sampleCycle();
    checkValue("single_ack_one_cycle", vec_t'(m0AckOut[0]), vec_t'(1'b0));
    tick();

    // round robin: four single-beat cycles per master, slave acks immediately
    rem = '{4, 4};
    dropNext = '{0, 0};
    idleSeen = 0;
    for (int n = 0; n < 60 && (rem[0] + rem[1]) > 0; n++) begin
      c0 = (rem[0] > 0) && !dropNext[0];
      c1 = (rem[1] > 0) && !dropNext[1];
      applyStimulus(c0, c0, c1, c1);
      sAck = 1'b1; sDatIn = $urandom;
      sampleCycle();
      dropNext = '{0, 0};
      if (m0AckOut[0] && c0) begin grantSeq.push_back(0); rem[0]--; dropNext[0] = 1; end
      if (m1AckOut[0] && c1) begin grantSeq.push_back(1); rem[1]--; dropNext[1] = 1; end
      if (grantSeq.size() > 0 && (rem[0] + rem[1]) > 0 && grantOut[0] == 2'b00) idleSeen++;
      tick();
    end
    checkValue("rr_beats", vec_t'(grantSeq.size()), vec_t'(8));
    checkValue("rr_no_idle", vec_t'(idleSeen), vec_t'(0));
    if (grantSeq.size() > 0) checkValue("rr_first_m1", vec_t'(grantSeq[0]), vec_t'(1));
    for (int i = 1; i < grantSeq.size(); i++) begin
      checkValue("rr_alternate", vec_t'(grantSeq[i]), vec_t'(1 - grantSeq[i-1]));
    end
    sAck = 1'b0;
    applyStimulus(0, 0, 0, 0);
    sampleCycle();
    tick();

    // grant lock: m1 bursts three beats while m0 waits
    applyStimulus(0, 0, 1, 1);
    sampleCycle();
    tick();
    m0Cyc = 1'b1; m0Stb = 1'b1; sAck = 1'b1;
    for (int b = 0; b < 3; b++) begin
      sampleCycle();
      checkValue("lock_burst", vec_t'({grantOut[0], m0AckOut[0], m1AckOut[0]}), vec_t'({2'b10, 1'b0, 1'b1}));
      tick();
    end
    m1Cyc = 1'b0; m1Stb = 1'b0; sAck = 1'b0;
    sampleCycle();
    checkValue("lock_handover_cycle", vec_t'({grantOut[0], m0AckOut[0]}), vec_t'({2'b10, 1'b0}));
    tick();
    sampleCycle();
    checkValue("lock_m0_after", vec_t'(grantOut[0]), vec_t'(2'b01));
    tick();
    applyStimulus(0, 0, 0, 0);
    sampleCycle();
    tick();

    // watchdog: slave never answers m0; m1 queues behind it
    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i <= 8; i++) begin
      if (i == 2) begin m1Cyc = 1'b1; m1Stb = 1'b1; end
      sampleCycle();
      checkValue("wd_pulse", vec_t'({m0ErrOut[0], timeoutOut[0]}), vec_t'((i == 8) ? 2'b11 : 2'b00));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      sampleCycle();
      checkValue("abort_parked", vec_t'({sCycOut[0], grantOut[0], m0ErrOut[0]}), vec_t'(4'b0000));
      tick();
    end
    m0Cyc = 1'b0; m0Stb = 1'b0;
    sampleCycle();
    tick();
    sampleCycle();
    checkValue("abort_then_m1", vec_t'(grantOut[0]), vec_t'(2'b10));
    tick();

    // asynchronous reset in the middle of a GNT1 beat
    sAck = 1'b1;
    sampleCycle();
    checkValue("pre_reset_m1_ack", vec_t'({grantOut[0], m1AckOut[0]}), vec_t'({2'b10, 1'b1}));
    tick();
    #2;
    rstN = 1'b0;
    #1;
    checkValue("async_reset_bus", vec_t'({grantOut[0], sCycOut[0], sStbOut[0], m1AckOut[0], m1ErrOut[0]}), vec_t'(6'b0));
    modelReset(0); modelReset(1);
    checkOutput();
    sampleCycle();
    tick();
    rstN = 1'b1;
    applyStimulus(1, 1, 1, 1);
    sAck = 1'b0;
    sampleCycle();
    tick();
    sampleCycle();
    checkValue("reset_tie_m0_first", vec_t'({grantOut[0], grantOut[1]}), vec_t'({2'b01, 2'b01}));
    tick();

    // randomized traffic
    prevM0Cyc = m0Cyc;
    prevGrantFp = grantOut[1];
    for (int n = 0; n < 700; n++) begin
      ackDiv = ((n / 100) % 2 == 0) ? 3 : 14;
      c0 = ($urandom_range(4) == 0) ? ~m0Cyc : m0Cyc;
      c1 = ($urandom_range(4) == 0) ? ~m1Cyc : m1Cyc;
      applyStimulus(c0, c0 ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0),
                    c1, c1 ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0));
      sAck   = ($urandom_range(ackDiv - 1) == 0);
      sErr   = ($urandom_range(19) == 0);
      sDatIn = $urandom;
      sampleCycle();
      if (grantOut[1] == 2'b10 && prevGrantFp != 2'b10) begin
        checkValue("fp_m1_only_when_m0_idle", vec_t'(prevM0Cyc), vec_t'(1'b0));
      end
      prevM0Cyc = m0Cyc;
      prevGrantFp = grantOut[1];
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
